// File: rtl/decode_queue_pkg.sv
// Shared RV32I decode definitions: opcodes, funct fields, inner instruction
// types and the decoded-entry record stored in the decode queue.
package decode_queue_pkg;

    localparam int INST_TYPE_W = 6;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [INST_TYPE_W-1:0] {
        IT_NOP   = 6'd0,
        IT_LUI   = 6'd1,
        IT_AUIPC = 6'd2,
        IT_JAL   = 6'd3,
        IT_JALR  = 6'd4,
        IT_BEQ   = 6'd5,
        IT_BNE   = 6'd6,
        IT_BLT   = 6'd7,
        IT_BGE   = 6'd8,
        IT_BLTU  = 6'd9,
        IT_BGEU  = 6'd10,
        IT_LB    = 6'd11,
        IT_LH    = 6'd12,
        IT_LW    = 6'd13,
        IT_LBU   = 6'd14,
        IT_LHU   = 6'd15,
        IT_SB    = 6'd16,
        IT_SH    = 6'd17,
        IT_SW    = 6'd18,
        IT_ADDI  = 6'd19,
        IT_SLTI  = 6'd20,
        IT_SLTIU = 6'd21,
        IT_XORI  = 6'd22,
        IT_ORI   = 6'd23,
        IT_ANDI  = 6'd24,
        IT_SLLI  = 6'd25,
        IT_SRLI  = 6'd26,
        IT_SRAI  = 6'd27,
        IT_ADD   = 6'd28,
        IT_SUB   = 6'd29,
        IT_SLL   = 6'd30,
        IT_SLT   = 6'd31,
        IT_SLTU  = 6'd32,
        IT_XOR   = 6'd33,
        IT_SRL   = 6'd34,
        IT_SRA   = 6'd35,
        IT_OR    = 6'd36,
        IT_AND   = 6'd37
    } inst_type_e;

    localparam inst_type_e NOP = IT_NOP;

    localparam logic [1:0] LSB_NONE  = 2'b00;
    localparam logic [1:0] LSB_LOAD  = 2'b10;
    localparam logic [1:0] LSB_STORE = 2'b11;

    localparam logic [2:0] GOAL_NONE = 3'b000;
    localparam logic [2:0] GOAL_BYTE = 3'b001;
    localparam logic [2:0] GOAL_HALF = 3'b010;
    localparam logic [2:0] GOAL_WORD = 3'b100;

    typedef struct packed {
        inst_type_e  inst_type;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [1:0]  to_lsb;
        logic [2:0]  lsb_goal;
        logic        occupy_rd;
        logic        illegal;
    } decoded_t;

    typedef struct packed {
        decoded_t    dec;
        logic [31:0] pc;
    } entry_t;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/rv32i_decode.sv
// Purely combinational RV32I decoder producing one queue-entry record.
module rv32i_decode
    import decode_queue_pkg::*;
(
    input  logic [31:0] inst,
    output decoded_t    dec
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign opcode = inst[6:0];
    assign f3     = inst[14:12];
    assign f7     = inst[31:25];
    assign imm_i  = sext12(inst[31:20]);
    assign imm_s  = sext12({inst[31:25], inst[11:7]});
    assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = {inst[31:12], 12'h000};
    assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    inst_type_e  ty;
    logic [31:0] imm;
    logic [1:0]  to_lsb;
    logic [2:0]  goal;
    logic        bad;
    logic        wr_rd;

    // Opcode/funct classification; illegal encodings are collapsed afterwards.
    always_comb begin
        ty     = IT_NOP;
        imm    = 32'h0;
        to_lsb = LSB_NONE;
        goal   = GOAL_NONE;
        bad    = 1'b0;
        wr_rd  = 1'b0;
        case (opcode)
            OPC_LUI:   begin ty = IT_LUI;   imm = imm_u; wr_rd = 1'b1; end
            OPC_AUIPC: begin ty = IT_AUIPC; imm = imm_u; wr_rd = 1'b1; end
            OPC_JAL:   begin ty = IT_JAL;   imm = imm_j; wr_rd = 1'b1; end
            OPC_JALR:  begin ty = IT_JALR;  imm = imm_i; wr_rd = 1'b1; end
            OPC_BRANCH: begin
                imm = imm_b;
                case (f3)
                    F3_BEQ:  ty = IT_BEQ;
                    F3_BNE:  ty = IT_BNE;
                    F3_BLT:  ty = IT_BLT;
                    F3_BGE:  ty = IT_BGE;
                    F3_BLTU: ty = IT_BLTU;
                    F3_BGEU: ty = IT_BGEU;
                    default: bad = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                imm    = imm_i;
                to_lsb = LSB_LOAD;
                wr_rd  = 1'b1;
                case (f3)
                    F3_LB:   begin ty = IT_LB;  goal = GOAL_BYTE; end
                    F3_LH:   begin ty = IT_LH;  goal = GOAL_HALF; end
                    F3_LW:   begin ty = IT_LW;  goal = GOAL_WORD; end
                    F3_LBU:  begin ty = IT_LBU; goal = GOAL_BYTE; end
                    F3_LHU:  begin ty = IT_LHU; goal = GOAL_HALF; end
                    default: bad = 1'b1;
                endcase
            end
            OPC_STORE: begin
                imm    = imm_s;
                to_lsb = LSB_STORE;
                case (f3)
                    F3_SB:   begin ty = IT_SB; goal = GOAL_BYTE; end
                    F3_SH:   begin ty = IT_SH; goal = GOAL_HALF; end
                    F3_SW:   begin ty = IT_SW; goal = GOAL_WORD; end
                    default: bad = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                imm   = imm_i;
                wr_rd = 1'b1;
                case (f3)
                    F3_ADD:  ty = IT_ADDI;
                    F3_SLT:  ty = IT_SLTI;
                    F3_SLTU: ty = IT_SLTIU;
                    F3_XOR:  ty = IT_XORI;
                    F3_OR:   ty = IT_ORI;
                    F3_AND:  ty = IT_ANDI;
                    F3_SLL: begin
                        if (f7 == F7_BASE) ty = IT_SLLI;
                        else               bad = 1'b1;
                    end
                    default: begin
                        if (f7 == F7_BASE)     ty = IT_SRLI;
                        else if (f7 == F7_ALT) ty = IT_SRAI;
                        else                   bad = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                wr_rd = 1'b1;
                case (f3)
                    F3_ADD: begin
                        if (f7 == F7_BASE)     ty = IT_ADD;
                        else if (f7 == F7_ALT) ty = IT_SUB;
                        else                   bad = 1'b1;
                    end
                    F3_SRL: begin
                        if (f7 == F7_BASE)     ty = IT_SRL;
                        else if (f7 == F7_ALT) ty = IT_SRA;
                        else                   bad = 1'b1;
                    end
                    default: begin
                        bad = (f7 != F7_BASE);
                        case (f3)
                            F3_SLL:  ty = IT_SLL;
                            F3_SLT:  ty = IT_SLT;
                            F3_SLTU: ty = IT_SLTU;
                            F3_XOR:  ty = IT_XOR;
                            F3_OR:   ty = IT_OR;
                            default: ty = IT_AND;
                        endcase
                    end
                endcase
            end
            default: bad = 1'b1;
        endcase
    end

    // Illegal encodings still flow through the queue, but as an inert NOP.
    always_comb begin
        dec.inst_type = bad ? NOP : ty;
        dec.imm       = bad ? 32'h0 : imm;
        dec.rs1       = inst[19:15];
        dec.rs2       = inst[24:20];
        dec.rd        = inst[11:7];
        dec.shamt     = inst[24:20];
        dec.to_lsb    = bad ? LSB_NONE : to_lsb;
        dec.lsb_goal  = bad ? GOAL_NONE : goal;
        dec.occupy_rd = !bad && wr_rd && (inst[11:7] != 5'd0);
        dec.illegal   = bad;
    end

endmodule

// File: rtl/decode_queue.sv
// Decoded-instruction FIFO between the fetcher and the dispatcher.
// Decode happens on the fetch side; the dispatcher sees registered entries.
module decode_queue #(
    parameter int DEPTH       = 4,
    parameter int INST_TYPE_W = decode_queue_pkg::INST_TYPE_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_in,
    input  logic                       fet_valid_in,
    input  logic [31:0]                fet_inst_in,
    input  logic [31:0]                fet_pc_in,
    output logic                       fet_ready_out,
    output logic                       dis_valid_out,
    input  logic                       dis_ready_in,
    output logic [INST_TYPE_W-1:0]     dis_inst_type_out,
    output logic [31:0]                dis_imm_out,
    output logic [4:0]                 dis_rs1_out,
    output logic [4:0]                 dis_rs2_out,
    output logic [4:0]                 dis_rd_out,
    output logic [4:0]                 dis_shamt_out,
    output logic [31:0]                dis_pc_out,
    output logic [1:0]                 dis_to_lsb_out,
    output logic [2:0]                 dis_lsb_goal_out,
    output logic                       dis_occupy_rd_out,
    output logic                       dis_illegal_out,
    output logic [$clog2(DEPTH):0]     count_out
);

    import decode_queue_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    decoded_t         dec;
    entry_t           mem [DEPTH];
    entry_t           head_e;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             enq;
    logic             deq;

    rv32i_decode u_decode (
        .inst (fet_inst_in),
        .dec  (dec)
    );

    // No bypass: a full queue refuses fetches even while it is being drained.
    assign fet_ready_out = (count < FULL_CNT) && !flush_in;
    assign dis_valid_out = (count != '0);
    assign enq           = fet_valid_in && fet_ready_out;
    assign deq           = dis_valid_out && dis_ready_in;

    // Pointers and occupancy; rst beats flush, flush beats any handshake.
    always_ff @(posedge clk) begin
        if (rst || flush_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + 1'b1;
            if (deq) head <= head + 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (!rst && enq) mem[tail] <= '{dec: dec, pc: fet_pc_in};
    end

    assign head_e            = mem[head];
    assign dis_inst_type_out = INST_TYPE_W'(head_e.dec.inst_type);
    assign dis_imm_out       = head_e.dec.imm;
    assign dis_rs1_out       = head_e.dec.rs1;
    assign dis_rs2_out       = head_e.dec.rs2;
    assign dis_rd_out        = head_e.dec.rd;
    assign dis_shamt_out     = head_e.dec.shamt;
    assign dis_pc_out        = head_e.pc;
    assign dis_to_lsb_out    = head_e.dec.to_lsb;
    assign dis_lsb_goal_out  = head_e.dec.lsb_goal;
    assign dis_occupy_rd_out = head_e.dec.occupy_rd;
    assign dis_illegal_out   = head_e.dec.illegal;
    assign count_out         = count;

endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of decoded-instruction entries; SHALL be a power of two, at least 2.
REQ-002 Parameter INST_TYPE_W, default 6, width of the inner instruction-type code.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 flush_in  input  1  misprediction flush; discards all entries.
REQ-006 fet_valid_in  input  1  fetcher presents an instruction.
REQ-007 fet_inst_in  input  32  raw RV32I instruction word.
REQ-008 fet_pc_in  input  32  PC of fet_inst_in.
REQ-009 fet_ready_out  output  1  queue can accept an instruction this cycle.
REQ-010 dis_valid_out  output  1  head entry is valid.
REQ-011 dis_ready_in  input  1  dispatcher consumes the head this cycle.
REQ-012 dis_inst_type_out  output  INST_TYPE_W  inner instruction type of the head; NOP when the head is illegal.
REQ-013 dis_imm_out  output  32  sign-extended immediate (I/S/B/U/J); 0 for R-type.
REQ-014 dis_rs1_out, dis_rs2_out, dis_rd_out  output  5 each  register indices from bits [19:15], [24:20] and [11:7].
REQ-015 dis_shamt_out  output  5  bits [24:20].
REQ-016 dis_pc_out  output  32  PC of the head.
REQ-017 dis_to_lsb_out  output  2  bit1 = goes to LSB, bit0 = store (1) or load (0).
REQ-018 dis_lsb_goal_out  output  3  access size one-hot: 001 byte, 010 half, 100 word; 000 for non-memory.
REQ-019 dis_occupy_rd_out  output  1  instruction renames rd.
REQ-020 dis_illegal_out  output  1  unsupported opcode, funct3 or funct7.
REQ-021 count_out  output  clog2(DEPTH)+1  number of valid entries.

Function
REQ-022 Decode SHALL be combinational on fet_inst_in; the decoded record plus PC SHALL be written into the tail entry on enqueue.
REQ-023 Enqueue occurs when fet_valid_in && fet_ready_out; fet_ready_out = (count < DEPTH) && !flush_in; there is no bypass when full, even if a dequeue occurs in the same cycle.
REQ-024 Dequeue occurs when dis_valid_out && dis_ready_in; dis_valid_out = (count != 0); all dis_* outputs are driven from the registered head entry.
REQ-025 Latency: an instruction enqueued at edge N SHALL be visible at the head after edge N when the queue was empty.
REQ-026 Simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers.
REQ-027 Head and tail pointers SHALL wrap modulo DEPTH; FIFO order SHALL be preserved across wrap.
REQ-028 flush_in SHALL take priority over both enqueue and dequeue: next cycle count=0 and pointers=0, and the same-cycle fetch is dropped.
REQ-029 Opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP SHALL map to inner types exactly as in the shared type table.
REQ-030 SRLI/SRAI and ADD/SUB SHALL be distinguished by funct7: 0000000 selects SRLI/ADD, 0100000 selects SRAI/SUB; any other funct7 value is illegal.
REQ-031 The following are illegal: any other opcode; branch funct3 010 or 011; load funct3 011, 110 or 111; store funct3 of 011 or higher; SLLI with a nonzero funct7.
REQ-032 Illegal entries SHALL still enqueue, with type NOP, imm 0, to_lsb 00, goal 000, occupy 0 and illegal 1.
REQ-033 dis_occupy_rd_out = 0 for BRANCH, STORE, illegal entries and any instruction with rd = x0; otherwise 1.
REQ-034 Loads SHALL drive to_lsb = 10 and stores SHALL drive to_lsb = 11; all other instructions drive 00.

Reset
REQ-035 On rst: count, head and tail = 0; dis_valid_out = 0; fet_ready_out = 1 in the following cycle; entry contents are don't-care.
REQ-036 rst SHALL override flush, enqueue and dequeue in the same cycle; an operation in flight mid-cycle is discarded.

Structure
REQ-037 Opcode, funct3/funct7 constants, inner instruction-type codes, NOP and INST_TYPE_W SHALL live in the shared header package.
REQ-038 Decode logic SHALL be one combinational sub-module, rv32i_decode; decode_queue SHALL contain the storage, pointers and handshake logic.

Verification
REQ-039 Enqueue 0x00500093 into an empty queue -> next cycle: valid=1, type ADDI, imm=5, rs1=0, rd=1, occupy=1, illegal=0.
REQ-040 Enqueue 0xFE20AE23 (sw x2,-4(x1)) -> imm=0xFFFFFFFC, to_lsb=11, goal=100, occupy=0, rs1=1, rs2=2.
REQ-041 DEPTH=4 with dis_ready_in=0 and 5 fetches -> after 4 enqueues count=4 and fet_ready_out=0; the 5th is held until one dequeue is followed by ready=1.
REQ-042 count=3 with flush_in and fet_valid_in in the same cycle -> next cycle count=0, valid=0, and the new instruction is absent.
REQ-043 Enqueue 0x0000007F, then 0x00000013 (addi x0,x0,0) -> the first has illegal=1, type NOP; the second has type ADDI, occupy=0.
REQ-044 Stream 10 instructions with continuous enqueue and dequeue, ready toggling randomly -> PCs exit in order across pointer wrap, with no loss or duplication.
